// File: rtl/interrupt_sequencer_pkg.sv
// interrupt_sequencer_pkg
// Shared types and constants for the interrupt sequencer:
//   - fixed jump targets for NMI and IM1
//   - FSM state and interrupt-mode enumerations
//   - helpers that decode an IM0 acknowledge byte as an RST opcode
package interrupt_sequencer_pkg;

  localparam logic [15:0] VEC_NMI = 16'h0066;
  localparam logic [15:0] VEC_IM1 = 16'h0038;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    NMI_TAKE = 3'd1,
    INT_ACK  = 3'd2,
    TBL_LO   = 3'd3,
    TBL_HI   = 3'd4,
    VECTOR   = 3'd5
  } irq_state_t;

  typedef enum logic [1:0] {
    IM0 = 2'd0,
    IM1 = 2'd1,
    IM2 = 2'd2
  } im_t;

  // RST opcodes have the form 11xxx111.
  function automatic logic is_rst_opcode(input logic [7:0] op);
    return ((op & 8'hC7) == 8'hC7);
  endfunction

  // RST target is the xxx field scaled by 8 in page zero.
  function automatic logic [15:0] rst_vector(input logic [7:0] op);
    return {8'h00, (op & 8'h38)};
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if
// Bus and vector handshake between the interrupt sequencer and its
// surroundings (bus unit and instruction sequencer).
//   master (interrupt sequencer): drives int_ack_req, mem_rd_req, mem_addr,
//                                 vector_valid, vector
//   slave  (bus / sequencer side): drives bus_done, data_in, vector_ack
interface interrupt_sequencer_if;
  logic        int_ack_req;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        bus_done;
  logic [7:0]  data_in;
  logic        vector_valid;
  logic [15:0] vector;
  logic        vector_ack;

  modport master (
    output int_ack_req, mem_rd_req, mem_addr, vector_valid, vector,
    input  bus_done, data_in, vector_ack
  );

  modport slave (
    input  int_ack_req, mem_rd_req, mem_addr, vector_valid, vector,
    output bus_done, data_in, vector_ack
  );
endinterface

// File: rtl/interrupt_sequencer_nmi_edge_latch.sv
// interrupt_sequencer_nmi_edge_latch
// Detects 0->1 edges on the (already synchronised) NMI line and holds a
// pending flag until the sequencer accepts the NMI.
//   clk, reset  : clock, async active-high reset
//   nmi         : NMI request level
//   clear       : drop the pending flag (NMI accepted)
//   nmi_pending : an NMI edge is waiting to be taken
module interrupt_sequencer_nmi_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic nmi,
  input  logic clear,
  output logic nmi_pending
);

  logic nmi_prev_q;
  logic pending_q;
  logic pending_d;

  // Pending flag next value; clearing wins, edges seen while pending are absorbed.
  always_comb begin
    pending_d = pending_q;
    if (clear) begin
      pending_d = 1'b0;
    end else if (nmi && !nmi_prev_q) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Edge-detect history and pending flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_prev_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      nmi_prev_q <= nmi;
      pending_q  <= pending_d;
    end
  end

  assign nmi_pending = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
// Chooses between a pending NMI and a maskable INT at instruction
// boundaries, runs the acknowledge / vector-table sequence and hands a
// 16-bit jump target to the instruction sequencer. Owns the IM register.
//   clk, reset                 : clock, async active-high reset
//   nmi, int_req               : interrupt requests (edge / level)
//   iff1, delayed_enable_interrupts, reg_i : from the I/R/IFF block
//   next_insn_done, halted     : instruction boundary qualifiers
//   im_wr, im_in               : IM instruction write
//   bus (master modport)       : ack / table-read bus cycles, vector handshake
//   accept_nmi, accept_int, exit_halt : one-cycle pulses at acceptance
//   busy, im, im0_unsupported  : status
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  nmi,
  input  logic                  int_req,
  input  logic                  iff1,
  input  logic                  delayed_enable_interrupts,
  input  logic [7:0]            reg_i,
  input  logic                  next_insn_done,
  input  logic                  halted,
  input  logic                  im_wr,
  input  logic [1:0]            im_in,
  interrupt_sequencer_if.master bus,
  output logic                  accept_nmi,
  output logic                  accept_int,
  output logic                  exit_halt,
  output logic                  busy,
  output logic [1:0]            im,
  output logic                  im0_unsupported
);

  irq_state_t  state_q, state_d;
  im_t         im_q, im_d;
  logic        accept_nmi_q, accept_nmi_d;
  logic        accept_int_q, accept_int_d;
  logic        exit_halt_q, exit_halt_d;
  logic        busy_q, busy_d;
  logic        int_ack_req_q, int_ack_req_d;
  logic        mem_rd_req_q, mem_rd_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        vector_valid_q, vector_valid_d;
  logic [15:0] vector_q, vector_d;
  logic        im0_unsup_q, im0_unsup_d;
  logic [6:0]  ack_idx_q, ack_idx_d;   // ack byte bits [7:1]; bit 0 of the table address is implied
  logic [7:0]  lo_q, lo_d;
  logic        nmi_pending;
  logic        boundary;

  // The pending flag drops once the NMI_TAKE cycle has run.
  interrupt_sequencer_nmi_edge_latch u_nmi_latch (
    .clk         (clk),
    .reset       (reset),
    .nmi         (nmi),
    .clear       (state_q == NMI_TAKE),
    .nmi_pending (nmi_pending)
  );

  assign boundary = (state_q == IDLE) && (next_insn_done || halted);

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d        = state_q;
    accept_nmi_d   = 1'b0;
    accept_int_d   = 1'b0;
    exit_halt_d    = 1'b0;
    busy_d         = busy_q;
    int_ack_req_d  = int_ack_req_q;
    mem_rd_req_d   = mem_rd_req_q;
    mem_addr_d     = mem_addr_q;
    vector_valid_d = vector_valid_q;
    vector_d       = vector_q;
    im0_unsup_d    = im0_unsup_q;
    ack_idx_d      = ack_idx_q;
    lo_d           = lo_q;

    // Mode 3 does not exist; such a write leaves the mode unchanged.
    if (im_wr && (im_in != 2'd3)) begin
      im_d = im_t'(im_in);
    end else begin
      im_d = im_q;
    end

    case (state_q)
      IDLE: begin
        if (boundary && nmi_pending) begin
          state_d      = NMI_TAKE;
          accept_nmi_d = 1'b1;
          exit_halt_d  = halted;
          busy_d       = 1'b1;
        end else if (boundary && int_req && iff1 && !delayed_enable_interrupts) begin
          state_d       = INT_ACK;
          accept_int_d  = 1'b1;
          exit_halt_d   = halted;
          busy_d        = 1'b1;
          int_ack_req_d = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      NMI_TAKE: begin
        vector_d       = VEC_NMI;
        vector_valid_d = 1'b1;
        state_d        = VECTOR;
      end
      INT_ACK: begin
        if (bus.bus_done) begin
          int_ack_req_d = 1'b0;
          ack_idx_d     = bus.data_in[7:1];
          case (im_q)
            IM0: begin
              if (is_rst_opcode(bus.data_in)) begin
                vector_d = rst_vector(bus.data_in);
              end else begin
                vector_d    = VEC_IM1;
                im0_unsup_d = 1'b1;
              end
              vector_valid_d = 1'b1;
              state_d        = VECTOR;
            end
            IM2: begin
              mem_rd_req_d = 1'b1;
              mem_addr_d   = {reg_i, bus.data_in[7:1], 1'b0};
              state_d      = TBL_LO;
            end
            default: begin
              vector_d       = VEC_IM1;
              vector_valid_d = 1'b1;
              state_d        = VECTOR;
            end
          endcase
        end else begin
          int_ack_req_d = 1'b1;
        end
      end
      TBL_LO: begin
        // High byte address only flips bit 0; no carry into reg_i.
        if (bus.bus_done) begin
          lo_d       = bus.data_in;
          mem_addr_d = {reg_i, ack_idx_q, 1'b1};
          state_d    = TBL_HI;
        end else begin
          mem_addr_d = {reg_i, ack_idx_q, 1'b0};
        end
      end
      TBL_HI: begin
        if (bus.bus_done) begin
          vector_d       = {bus.data_in, lo_q};
          mem_rd_req_d   = 1'b0;
          vector_valid_d = 1'b1;
          state_d        = VECTOR;
        end else begin
          mem_addr_d = {reg_i, ack_idx_q, 1'b1};
        end
      end
      VECTOR: begin
        if (bus.vector_ack) begin
          vector_valid_d = 1'b0;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end else begin
          state_d = VECTOR;
        end
      end
      default: begin
        state_d        = IDLE;
        busy_d         = 1'b0;
        int_ack_req_d  = 1'b0;
        mem_rd_req_d   = 1'b0;
        vector_valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      im_q           <= IM0;
      accept_nmi_q   <= 1'b0;
      accept_int_q   <= 1'b0;
      exit_halt_q    <= 1'b0;
      busy_q         <= 1'b0;
      int_ack_req_q  <= 1'b0;
      mem_rd_req_q   <= 1'b0;
      mem_addr_q     <= 16'h0000;
      vector_valid_q <= 1'b0;
      vector_q       <= 16'h0000;
      im0_unsup_q    <= 1'b0;
      ack_idx_q      <= 7'h00;
      lo_q           <= 8'h00;
    end else begin
      state_q        <= state_d;
      im_q           <= im_d;
      accept_nmi_q   <= accept_nmi_d;
      accept_int_q   <= accept_int_d;
      exit_halt_q    <= exit_halt_d;
      busy_q         <= busy_d;
      int_ack_req_q  <= int_ack_req_d;
      mem_rd_req_q   <= mem_rd_req_d;
      mem_addr_q     <= mem_addr_d;
      vector_valid_q <= vector_valid_d;
      vector_q       <= vector_d;
      im0_unsup_q    <= im0_unsup_d;
      ack_idx_q      <= ack_idx_d;
      lo_q           <= lo_d;
    end
  end

  assign accept_nmi       = accept_nmi_q;
  assign accept_int       = accept_int_q;
  assign exit_halt        = exit_halt_q;
  assign busy             = busy_q;
  assign im               = im_q;
  assign im0_unsupported  = im0_unsup_q;
  assign bus.int_ack_req  = int_ack_req_q;
  assign bus.mem_rd_req   = mem_rd_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.vector       = vector_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer
// Directed self-checking bench for interrupt_sequencer. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_interrupt_sequencer;

  logic       clk;
  logic       reset;
  logic       nmi;
  logic       int_req;
  logic       iff1;
  logic       dei;
  logic [7:0] reg_i;
  logic       nid;
  logic       halted;
  logic       im_wr;
  logic [1:0] im_in;
  logic       accept_nmi;
  logic       accept_int;
  logic       exit_halt;
  logic       busy;
  logic [1:0] im;
  logic       im0_unsupported;

  int passed;
  int total;

  interrupt_sequencer_if bus_if ();

  interrupt_sequencer dut (
    .clk                       (clk),
    .reset                     (reset),
    .nmi                       (nmi),
    .int_req                   (int_req),
    .iff1                      (iff1),
    .delayed_enable_interrupts (dei),
    .reg_i                     (reg_i),
    .next_insn_done            (nid),
    .halted                    (halted),
    .im_wr                     (im_wr),
    .im_in                     (im_in),
    .bus                       (bus_if),
    .accept_nmi                (accept_nmi),
    .accept_int                (accept_int),
    .exit_halt                 (exit_halt),
    .busy                      (busy),
    .im                        (im),
    .im0_unsupported           (im0_unsupported)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_im(input logic [1:0] m);
    im_wr = 1'b1;
    im_in = m;
    tick();
    im_wr = 1'b0;
  endtask

  task automatic ack_vector();
    bus_if.vector_ack = 1'b1;
    tick();
    bus_if.vector_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({accept_nmi, accept_int, exit_halt, busy, bus_if.int_ack_req, bus_if.mem_rd_req,
         bus_if.vector_valid, im0_unsupported} !== 8'h00)
      $display("FAIL reset_flags: got %b expected 00000000",
               {accept_nmi, accept_int, exit_halt, busy, bus_if.int_ack_req,
                bus_if.mem_rd_req, bus_if.vector_valid, im0_unsupported});
    else passed++;
    total++;
    if ({im, bus_if.vector, bus_if.mem_addr} !== 34'h0)
      $display("FAIL reset_values: got im=%0d vec=%h addr=%h expected 0/0000/0000",
               im, bus_if.vector, bus_if.mem_addr);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nmi();
    nmi = 1'b1;
    tick();
    nmi = 1'b0;
    nid = 1'b1;
    tick();
    total++;
    if ({accept_nmi, accept_int, busy, exit_halt} !== 4'b1010)
      $display("FAIL nmi_accept: got an/ai/busy/eh=%b expected 1010",
               {accept_nmi, accept_int, busy, exit_halt});
    else passed++;
    nid = 1'b0;
    tick();
    total++;
    if ({accept_nmi, bus_if.vector_valid} !== 2'b01 || bus_if.vector !== 16'h0066)
      $display("FAIL nmi_vector: got an=%b vv=%b vec=%h expected 0 1 0066",
               accept_nmi, bus_if.vector_valid, bus_if.vector);
    else passed++;
    ack_vector();
    total++;
    if ({busy, bus_if.vector_valid} !== 2'b00)
      $display("FAIL nmi_done: got busy=%b vv=%b expected 0 0", busy, bus_if.vector_valid);
    else passed++;
    // Pending flag must have been consumed: another boundary takes nothing.
    nid = 1'b1;
    tick();
    nid = 1'b0;
    total++;
    if ({accept_nmi, busy} !== 2'b00)
      $display("FAIL nmi_once: got an=%b busy=%b expected 0 0", accept_nmi, busy);
    else passed++;
  endtask

  task automatic test_im1_int();
    write_im(2'd1);
    total++;
    if (im !== 2'd1) $display("FAIL im_write: got %0d expected 1", im);
    else passed++;
    write_im(2'd3);
    total++;
    if (im !== 2'd1) $display("FAIL im_write3_ignored: got %0d expected 1", im);
    else passed++;
    iff1 = 1'b1;
    int_req = 1'b1;
    nid = 1'b1;
    tick();
    nid = 1'b0;
    int_req = 1'b0;
    total++;
    if ({accept_int, bus_if.int_ack_req, busy, bus_if.mem_rd_req} !== 4'b1110)
      $display("FAIL int_accept: got ai/iar/busy/mrd=%b expected 1110",
               {accept_int, bus_if.int_ack_req, busy, bus_if.mem_rd_req});
    else passed++;
    tick();
    total++;
    if ({accept_int, bus_if.int_ack_req} !== 2'b01)
      $display("FAIL int_ack_hold: got ai/iar=%b expected 01", {accept_int, bus_if.int_ack_req});
    else passed++;
    bus_if.bus_done = 1'b1;
    bus_if.data_in = 8'hFF;
    tick();
    bus_if.bus_done = 1'b0;
    total++;
    if (bus_if.int_ack_req !== 1'b0 || bus_if.vector_valid !== 1'b1 || bus_if.vector !== 16'h0038)
      $display("FAIL im1_vector: got iar=%b vv=%b vec=%h expected 0 1 0038",
               bus_if.int_ack_req, bus_if.vector_valid, bus_if.vector);
    else passed++;
    ack_vector();
  endtask

  task automatic test_im2();
    write_im(2'd2);
    reg_i = 8'h12;
    int_req = 1'b1;
    nid = 1'b1;
    tick();
    nid = 1'b0;
    int_req = 1'b0;
    bus_if.bus_done = 1'b1;
    bus_if.data_in = 8'h35;
    tick();
    bus_if.bus_done = 1'b0;
    total++;
    if ({bus_if.int_ack_req, bus_if.mem_rd_req} !== 2'b01 || bus_if.mem_addr !== 16'h1234)
      $display("FAIL im2_lo_addr: got iar=%b mrd=%b addr=%h expected 0 1 1234",
               bus_if.int_ack_req, bus_if.mem_rd_req, bus_if.mem_addr);
    else passed++;
    tick();
    bus_if.bus_done = 1'b1;
    bus_if.data_in = 8'hCD;
    tick();
    total++;
    if (bus_if.mem_rd_req !== 1'b1 || bus_if.mem_addr !== 16'h1235)
      $display("FAIL im2_hi_addr: got mrd=%b addr=%h expected 1 1235",
               bus_if.mem_rd_req, bus_if.mem_addr);
    else passed++;
    bus_if.data_in = 8'hAB;
    tick();
    bus_if.bus_done = 1'b0;
    total++;
    if (bus_if.mem_rd_req !== 1'b0 || bus_if.vector_valid !== 1'b1 || bus_if.vector !== 16'hABCD)
      $display("FAIL im2_vector: got mrd=%b vv=%b vec=%h expected 0 1 ABCD",
               bus_if.mem_rd_req, bus_if.vector_valid, bus_if.vector);
    else passed++;
    tick();
    total++;
    if (bus_if.vector !== 16'hABCD || bus_if.vector_valid !== 1'b1)
      $display("FAIL im2_vector_hold: got vv=%b vec=%h expected 1 ABCD",
               bus_if.vector_valid, bus_if.vector);
    else passed++;
    ack_vector();
  endtask

  task automatic test_im0();
    write_im(2'd0);
    int_req = 1'b1;
    nid = 1'b1;
    tick();
    nid = 1'b0;
    bus_if.bus_done = 1'b1;
    bus_if.data_in = 8'hD7;  // RST 10h
    tick();
    bus_if.bus_done = 1'b0;
    total++;
    if (bus_if.vector !== 16'h0010 || im0_unsupported !== 1'b0)
      $display("FAIL im0_rst: got vec=%h unsup=%b expected 0010 0", bus_if.vector, im0_unsupported);
    else passed++;
    ack_vector();
    nid = 1'b1;
    tick();
    nid = 1'b0;
    int_req = 1'b0;
    bus_if.bus_done = 1'b1;
    bus_if.data_in = 8'h00;  // not an RST opcode
    tick();
    bus_if.bus_done = 1'b0;
    total++;
    if (bus_if.vector !== 16'h0038 || im0_unsupported !== 1'b1)
      $display("FAIL im0_non_rst: got vec=%h unsup=%b expected 0038 1", bus_if.vector, im0_unsupported);
    else passed++;
    ack_vector();
  endtask

  task automatic test_ei_shadow();
    write_im(2'd1);
    int_req = 1'b1;
    dei = 1'b1;
    nid = 1'b1;
    tick();
    total++;
    if ({accept_int, busy} !== 2'b00)
      $display("FAIL ei_shadow_block: got ai=%b busy=%b expected 0 0", accept_int, busy);
    else passed++;
    dei = 1'b0;
    tick();
    nid = 1'b0;
    int_req = 1'b0;
    total++;
    if (accept_int !== 1'b1)
      $display("FAIL ei_shadow_release: got ai=%b expected 1", accept_int);
    else passed++;
    bus_if.bus_done = 1'b1;
    bus_if.data_in = 8'hFF;
    tick();
    bus_if.bus_done = 1'b0;
    // Acknowledge in the same cycle vector_valid first appears.
    ack_vector();
    total++;
    if (busy !== 1'b0) $display("FAIL ei_shadow_done: got busy=%b expected 0", busy);
    else passed++;
  endtask

  task automatic test_priority();
    nmi = 1'b1;
    tick();
    nmi = 1'b0;
    int_req = 1'b1;
    nid = 1'b1;
    tick();
    nid = 1'b0;
    total++;
    if ({accept_nmi, accept_int} !== 2'b10)
      $display("FAIL prio_nmi_first: got an/ai=%b expected 10", {accept_nmi, accept_int});
    else passed++;
    tick();
    ack_vector();
    nid = 1'b1;
    tick();
    nid = 1'b0;
    int_req = 1'b0;
    total++;
    if ({accept_nmi, accept_int} !== 2'b01)
      $display("FAIL prio_int_next: got an/ai=%b expected 01", {accept_nmi, accept_int});
    else passed++;
    bus_if.bus_done = 1'b1;
    bus_if.data_in = 8'hFF;
    tick();
    bus_if.bus_done = 1'b0;
    ack_vector();
  endtask

  task automatic test_halt();
    halted = 1'b1;
    nmi = 1'b1;
    tick();
    nmi = 1'b0;
    tick();
    halted = 1'b0;
    total++;
    if ({accept_nmi, exit_halt} !== 2'b11)
      $display("FAIL halt_exit: got an/eh=%b expected 11", {accept_nmi, exit_halt});
    else passed++;
    tick();
    total++;
    if ({accept_nmi, exit_halt, bus_if.vector_valid} !== 3'b001)
      $display("FAIL halt_exit_pulse: got an/eh/vv=%b expected 001",
               {accept_nmi, exit_halt, bus_if.vector_valid});
    else passed++;
    ack_vector();
  endtask

  task automatic test_reset_mid();
    write_im(2'd2);
    reg_i = 8'h12;
    int_req = 1'b1;
    nid = 1'b1;
    tick();
    nid = 1'b0;
    int_req = 1'b0;
    bus_if.bus_done = 1'b1;
    bus_if.data_in = 8'h35;
    tick();
    bus_if.bus_done = 1'b0;
    total++;
    if (bus_if.mem_rd_req !== 1'b1)
      $display("FAIL mid_in_tbl_lo: got mrd=%b expected 1", bus_if.mem_rd_req);
    else passed++;
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, bus_if.mem_rd_req, bus_if.int_ack_req, bus_if.vector_valid, im} !== 6'b000000 ||
        bus_if.mem_addr !== 16'h0000)
      $display("FAIL mid_reset: got busy/mrd/iar/vv/im=%b addr=%h expected 000000 0000",
               {busy, bus_if.mem_rd_req, bus_if.int_ack_req, bus_if.vector_valid, im},
               bus_if.mem_addr);
    else passed++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1;
    nmi = 1'b0;
    int_req = 1'b0;
    iff1 = 1'b0;
    dei = 1'b0;
    reg_i = 8'h00;
    nid = 1'b0;
    halted = 1'b0;
    im_wr = 1'b0;
    im_in = 2'd0;
    bus_if.bus_done = 1'b0;
    bus_if.data_in = 8'h00;
    bus_if.vector_ack = 1'b0;
    test_reset();
    test_nmi();
    test_im1_int();
    test_im2();
    test_im0();
    test_ei_shadow();
    test_priority();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
